aes_spi: RTL and testbench
==========================

AES_SPI -- requirements
Module: aes_spi

Interface
REQ-001 Parameter K, default 128: key width; legal values 128, 192, 256.
REQ-002 Parameter SYNC_STAGES, default 2: flops in each sck/cs_n/sdi synchronizer; minimum 2.
REQ-003 clk  input  1  system clock; all logic on posedge clk; one clock only.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sck  input  1  host SPI clock, asynchronous to clk, oversampled in the clk domain.
REQ-006 cs_n  input  1  host chip select, active-low; frames every transfer.
REQ-007 sdi  input  1  host-to-block serial data, MSB first.
REQ-008 sdo  output  1  block-to-host serial data, MSB first.
REQ-009 ce  output  1  one-cycle start pulse to the AES core.
REQ-010 dir  output  1  captured direction: 0 encrypt, 1 decrypt.
REQ-011 key  output  K  captured key.
REQ-012 message  output  128  captured message.
REQ-013 core_done  input  1  AES core completion flag, level.
REQ-014 translated  input  128  AES core result.
REQ-015 done  output  1  result ready for host readout.

Function
REQ-016 sck, cs_n and sdi shall each pass through SYNC_STAGES flops, followed by a one-flop edge detector on sck and cs_n.
REQ-017 The FSM shall have states IDLE, LOAD, START, BUSY, READY, READ.
REQ-018 IDLE -> LOAD on synchronized cs_n falling; the bit counter clears.
REQ-019 In LOAD, each synchronized sck rising edge shall shift sdi into the LSB of a (1+K+128)-bit register and increment the bit counter.
REQ-020 The bit counter shall saturate at 1+K+128+1 and never wrap.
REQ-021 Frame order: dir bit, then K key bits, then 128 message bits.
REQ-022 LOAD -> START on synchronized cs_n rising.
- On entry to START: dir, key and message load from the shift register.
- The bit-count check follows REQ-039/040.
REQ-023 ce shall be high for exactly the one cycle spent in START; START -> BUSY unconditionally.
REQ-024 BUSY shall ignore core_done in its first cycle, so a stale done from a previous run is masked.
REQ-025 From the second BUSY cycle on, core_done=1 shall capture translated into the output shift register and move to READY.
REQ-026 done shall be 1 in READY and 0 in every other state.
REQ-027 In BUSY and READY, sck and sdi shall be ignored; a cs_n fall in BUSY shall not start a new frame.
REQ-028 READY -> READ on synchronized cs_n falling.
- sdo drives bit 127 of the result.
REQ-029 In READ, each synchronized sck falling edge shall shift the result left by one; sdo always equals the register MSB.
REQ-030 READ -> IDLE on synchronized cs_n rising, whether or not all 128 bits were read.
- Bits after the 128th read as 0.
REQ-031 sdo shall be 0 in every state other than READ.
REQ-032 If a cs_n edge and an sck edge are detected in the same cycle, the cs_n edge shall take priority.
- The sck edge is dropped.

Reset
REQ-033 reset=1 shall force IDLE immediately, independent of clk.
REQ-034 Reset values: ce=0, done=0, sdo=0, dir=0, key=0, message=0, bit counter=0, shift registers=0.
REQ-035 Synchronizer reset values: sck chain 0, cs_n chain 1, sdi chain 0.
REQ-036 Reset in any state, including mid-LOAD or mid-READ, shall abandon the transfer with no ce pulse.

Configuration
REQ-037 Macro AES_SPI_FRAMECHECK_EN shall control frame-length checking.
REQ-038 When defined, output frame_err (1 bit, reset 0) shall be added.
REQ-039 With the macro defined, a LOAD->START transition with bit count != 1+K+128 shall:
- go to IDLE instead of START;
- suppress ce and leave dir/key/message unchanged;
- set frame_err.
REQ-040 With the macro defined, frame_err shall clear on the next cs_n falling edge in IDLE.
REQ-041 Without the macro, there is no frame_err port, no length check, and START is always entered on cs_n rising.

Verification
REQ-042 Full frame, K=128:
- Stimulus: dir=0, key 000102030405060708090a0b0c0d0e0f, message 00112233445566778899aabbccddeeff.
- Response: key and message match; exactly one ce pulse, SYNC_STAGES+2 clk after cs_n rise.
REQ-043 Result readout:
- Stimulus: stub holds core_done=1 before ce; it asserts again 11 cycles after ce with translated 69c4e0d86a7b0430d8cdb78070b4c55a.
- Response: done=0 until the second assertion, then 1; readout shifts out 69c4e0d8...c55a MSB first; done=0 after cs_n fall.
REQ-044 Short frame, macro defined:
- Stimulus: 100-bit frame.
- Response: no ce, frame_err=1, key unchanged; next valid frame clears frame_err and pulses ce.
REQ-045 Reset mid-frame:
- Stimulus: reset asserted after 60 bits.
- Response: state IDLE, all outputs 0; next full frame pulses ce once with correct key.
REQ-046 Ignored and aborted transfers:
- Stimulus: 20 sck toggles in BUSY.
- Response: result unaffected.
- Stimulus: READ aborted by cs_n rise after 64 bits.
- Response: IDLE, done=0, sdo=0.

Source files
------------

// File: rtl/aes_spi_if.sv
// aes_spi_if: host-side SPI pins of aes_spi.
// master = SPI host (drives sck/cs_n/sdi), slave = aes_spi (drives sdo).
interface aes_spi_if;
    logic sck;
    logic cs_n;
    logic sdi;
    logic sdo;

    modport master (output sck, output cs_n, output sdi, input sdo);
    modport slave  (input sck, input cs_n, input sdi, output sdo);
endinterface

// File: rtl/aes_spi.sv
// aes_spi: SPI front end for an AES core.
// The host shifts in a frame of {dir, key[K-1:0], message[127:0]}, MSB first.
// The block pulses ce, waits for core_done, and returns the 128-bit result on sdo.
// The SPI pins are oversampled in the clk domain.
// Optional macro AES_SPI_FRAMECHECK_EN adds a frame_err output. With it, any frame
// whose length is not exactly 1+K+128 bits is rejected.
module aes_spi #(
    parameter int unsigned K           = 128,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           reset,
    aes_spi_if.slave       spi,
    output logic           ce,
    output logic           dir,
    output logic [K-1:0]   key,
    output logic [127:0]   message,
    input  logic           core_done,
    input  logic [127:0]   translated,
    output logic           done
`ifdef AES_SPI_FRAMECHECK_EN
    ,
    output logic           frame_err
`endif
);

    localparam int unsigned FRAME = 1 + K + 128;
    localparam int unsigned CW    = $clog2(FRAME + 2);

    typedef enum logic [2:0] {IDLE, LOAD, START, BUSY, READY, READ} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, sdi_sync;
    logic sck_q, cs_q, sdi_q;
    logic sck_rise, sck_fall, cs_rise, cs_fall;
    logic sck_rise_ok, sck_fall_ok;

    logic [CW-1:0]    bit_cnt;
    logic [FRAME-1:0] in_sr;
    logic [127:0]     out_sr;
    logic             busy_armed;

    logic clr_cnt, shift_in, load_out, capture, shift_out;
`ifdef AES_SPI_FRAMECHECK_EN
    logic set_err, clr_err;
`endif

    // Synchronize the asynchronous SPI pins into the clk domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync <= '0;
            cs_sync  <= '1;
            sdi_sync <= '0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi.sck};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0],  spi.cs_n};
            sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], spi.sdi};
        end
    end

    // Edge strobes are registered. sdi_q is delayed alongside them, so the data bit
    // seen with an sck strobe was sampled in the same cycle as that sck edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_q    <= 1'b0;
            cs_q     <= 1'b1;
            sdi_q    <= 1'b0;
            sck_rise <= 1'b0;
            sck_fall <= 1'b0;
            cs_rise  <= 1'b0;
            cs_fall  <= 1'b0;
        end else begin
            sck_q    <= sck_sync[SYNC_STAGES-1];
            cs_q     <= cs_sync[SYNC_STAGES-1];
            sdi_q    <= sdi_sync[SYNC_STAGES-1];
            sck_rise <=  sck_sync[SYNC_STAGES-1] & ~sck_q;
            sck_fall <= ~sck_sync[SYNC_STAGES-1] &  sck_q;
            cs_rise  <=  cs_sync[SYNC_STAGES-1]  & ~cs_q;
            cs_fall  <= ~cs_sync[SYNC_STAGES-1]  &  cs_q;
        end
    end

    // A chip-select edge wins; an sck edge detected in the same cycle is dropped.
    assign sck_rise_ok = sck_rise & ~(cs_rise | cs_fall);
    assign sck_fall_ok = sck_fall & ~(cs_rise | cs_fall);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic and per-state control strobes.
    always_comb begin
        state_next = state;
        ce         = 1'b0;
        done       = 1'b0;
        clr_cnt    = 1'b0;
        shift_in   = 1'b0;
        load_out   = 1'b0;
        capture    = 1'b0;
        shift_out  = 1'b0;
`ifdef AES_SPI_FRAMECHECK_EN
        set_err    = 1'b0;
        clr_err    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next = LOAD;
                    clr_cnt    = 1'b1;
`ifdef AES_SPI_FRAMECHECK_EN
                    clr_err    = 1'b1;
`endif
                end
            end
            LOAD: begin
                if (cs_rise) begin
`ifdef AES_SPI_FRAMECHECK_EN
                    if (bit_cnt != CW'(FRAME)) begin
                        state_next = IDLE;
                        set_err    = 1'b1;
                    end else begin
                        state_next = START;
                        load_out   = 1'b1;
                    end
`else
                    state_next = START;
                    load_out   = 1'b1;
`endif
                end else if (sck_rise_ok) begin
                    shift_in = 1'b1;
                end
            end
            START: begin
                ce         = 1'b1;
                state_next = BUSY;
            end
            BUSY: begin
                if (busy_armed && core_done) begin
                    capture    = 1'b1;
                    state_next = READY;
                end
            end
            READY: begin
                done = 1'b1;
                if (cs_fall) state_next = READ;
            end
            READ: begin
                if (cs_rise)          state_next = IDLE;
                else if (sck_fall_ok) shift_out  = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // Frame capture, result shifting and the bit counter.
    // The bit counter saturates at FRAME+1, so an over-long frame never wraps back to a legal count.
    // busy_armed is 0 during the first BUSY cycle, so a stale core_done is not taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt    <= '0;
            in_sr      <= '0;
            out_sr     <= '0;
            dir        <= 1'b0;
            key        <= '0;
            message    <= '0;
            busy_armed <= 1'b0;
        end else begin
            busy_armed <= (state == BUSY);
            if (clr_cnt)
                bit_cnt <= '0;
            else if (shift_in && bit_cnt != CW'(FRAME + 1))
                bit_cnt <= bit_cnt + 1'b1;
            if (shift_in)
                in_sr <= {in_sr[FRAME-2:0], sdi_q};
            if (load_out) begin
                dir     <= in_sr[FRAME-1];
                key     <= in_sr[128 +: K];
                message <= in_sr[127:0];
            end
            if (capture)
                out_sr <= translated;
            else if (shift_out)
                out_sr <= {out_sr[126:0], 1'b0};
        end
    end

`ifdef AES_SPI_FRAMECHECK_EN
    // Sticky frame-length error; cleared when the next frame starts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        frame_err <= 1'b0;
        else if (set_err) frame_err <= 1'b1;
        else if (clr_err) frame_err <= 1'b0;
    end
`endif

    assign spi.sdo = (state == READ) ? out_sr[127] : 1'b0;

endmodule

// File: tb/tb_aes_spi.sv
// tb_aes_spi: self-checking bench for aes_spi with a scoreboard and a behavioural core stub.
// Define AES_SPI_FRAMECHECK_EN to also exercise the frame-length check.
module tb_aes_spi;
    localparam int unsigned K     = 128;
    localparam int unsigned S     = 2;
    localparam int unsigned FRAME = 1 + K + 128;
    localparam int          H     = 6;

    typedef struct { logic d; logic [K-1:0] k; logic [127:0] m; } frame_t;
    typedef struct { logic [127:0] r; int n; } rd_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           ce, dir, done, core_done;
    logic [K-1:0]   key;
    logic [127:0]   message, translated;
`ifdef AES_SPI_FRAMECHECK_EN
    logic           frame_err;
`endif

    aes_spi_if spi();

    aes_spi #(.K(K), .SYNC_STAGES(S)) dut (
        .clk        (clk),
        .reset      (reset),
        .spi        (spi),
        .ce         (ce),
        .dir        (dir),
        .key        (key),
        .message    (message),
        .core_done  (core_done),
        .translated (translated),
        .done       (done)
`ifdef AES_SPI_FRAMECHECK_EN
        ,
        .frame_err  (frame_err)
`endif
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int rise_cyc    = 0;
    int done_delay  = 11;

    logic [127:0] next_result = '0;
    logic [127:0] cur_result  = '0;
    logic         mdl_dir     = 1'b0;
    logic [K-1:0] mdl_key     = '0;
    logic [127:0] mdl_msg     = '0;

    frame_t exp_frames[$];
    rd_t    exp_reads[$];
    logic [255:0] obs = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
        return r;
    endfunction

    // Host side: shift n bits of f (f[n-1] first); optionally close the frame.
    task automatic send_bits(input logic [511:0] f, input int n, input bit close);
        tick(1);
        spi.cs_n = 1'b0;
        tick(3 * H);
        for (int i = n - 1; i >= 0; i--) begin
            spi.sdi = f[i];
            tick(H);
            spi.sck = 1'b1;
            tick(H);
            spi.sck = 1'b0;
        end
        if (close) begin
            tick(H);
            spi.cs_n = 1'b1;
            rise_cyc = cyc;
            tick(3 * H);
        end
    endtask

    task automatic send_frame(input logic d, input logic [K-1:0] k, input logic [127:0] m);
        frame_t       f;
        logic [511:0] bits;
        bits = '0;
        bits[FRAME-1:0] = {d, k, m};
        f.d = d; f.k = k; f.m = m;
        exp_frames.push_back(f);
        mdl_dir = d; mdl_key = k; mdl_msg = m;
        send_bits(bits, FRAME, 1'b1);
    endtask

    task automatic read_result(input int n);
        int  t;
        rd_t rd;
        t = 0;
        while (done !== 1'b1 && t < 1000) begin
            tick(1);
            t++;
        end
        check("done_before_read", 256'(done), 256'd1);
        rd.r = cur_result;
        rd.n = n;
        exp_reads.push_back(rd);
        spi.cs_n = 1'b0;
        tick(3 * H);
        check("done_in_read", 256'(done), 256'd0);
        for (int i = 0; i < n; i++) begin
            spi.sck = 1'b1;
            tick(H);
            spi.sck = 1'b0;
            tick(H);
        end
        spi.cs_n = 1'b1;
        tick(3 * H);
        check("idle_done", 256'(done), 256'd0);
        check("idle_sdo", 256'(spi.sdo), 256'd0);
    endtask

    // Monitor: every ce pulse must match the oldest outstanding frame.
    always @(negedge clk) begin
        frame_t f;
        if (reset === 1'b0 && ce === 1'b1) begin
            if (exp_frames.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL ce_unexpected: got ce=1 expected no pulse");
            end else begin
                f = exp_frames.pop_front();
                check("ce_dir", 256'(dir), 256'(f.d));
                check("ce_key", 256'(key), 256'(f.k));
                check("ce_message", 256'(message), 256'(f.m));
                check("ce_latency", 256'(cyc - rise_cyc), 256'(S + 2));
            end
        end
    end

    // Monitor: host samples sdo on sck rising; the readout is compared when cs_n rises.
    always @(posedge spi.sck or posedge spi.cs_n) begin
        rd_t          rd;
        logic [255:0] exp;
        if (exp_reads.size() > 0) begin
            if (spi.cs_n === 1'b1) begin
                rd  = exp_reads.pop_front();
                exp = {rd.r, 128'b0} >> (256 - rd.n);
                check("readout", obs, exp);
                obs = '0;
            end else begin
                obs = {obs[254:0], spi.sdo};
            end
        end
    end

    // Core stub: core_done stays high from the previous run (stale) until two cycles after ce.
    // It asserts again done_delay cycles after ce with a new result.
    initial begin
        int early;
        core_done  = 1'b1;
        translated = '0;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && ce === 1'b1) begin
                early = 0;
                for (int i = 0; i < done_delay; i++) begin
                    tick(1);
                    if (i == 1) core_done = 1'b0;
                    if (done !== 1'b0) early++;
                end
                translated = next_result;
                cur_result = next_result;
                core_done  = 1'b1;
                tick(1);
                check("done_early_cycles", 256'(early), 256'd0);
                check("done_rise", 256'(done), 256'd1);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] r;
        logic [511:0] junk;
        logic         d;
        logic [K-1:0] k;
        logic [127:0] m;
        int           n;

        spi.sck  = 1'b0;
        spi.cs_n = 1'b1;
        spi.sdi  = 1'b0;
        reset    = 1'b1;
        tick(5);
        reset = 1'b0;
        tick(3);
        check("reset_ce", 256'(ce), 256'd0);
        check("reset_done", 256'(done), 256'd0);
        check("reset_sdo", 256'(spi.sdo), 256'd0);
        check("reset_dir", 256'(dir), 256'd0);
        check("reset_key", 256'(key), 256'd0);
        check("reset_message", 256'(message), 256'd0);
`ifdef AES_SPI_FRAMECHECK_EN
        check("reset_frame_err", 256'(frame_err), 256'd0);
`endif

        // Known-answer frame, then full readout
        next_result = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        done_delay  = 11;
        send_frame(1'b0, K'(128'h000102030405060708090a0b0c0d0e0f),
                   128'h00112233445566778899aabbccddeeff);
        read_result(128);

        // Random frames: full read, aborted read, over-long read
        for (int t = 0; t < 4; t++) begin
            d = 1'($urandom_range(0, 1));
            r = rand256(); k = r[K-1:0];
            r = rand256(); m = r[127:0];
            r = rand256(); next_result = r[127:0];
            done_delay = int'($urandom_range(2, 40));
            send_frame(d, k, m);
            n = (t == 1) ? 64 : ((t == 2) ? 130 : 128);
            read_result(n);
        end

        // sck and sdi activity while BUSY must not disturb the result
        r = rand256(); k = r[K-1:0];
        r = rand256(); m = r[127:0];
        r = rand256(); next_result = r[127:0];
        done_delay = 200;
        send_frame(1'b1, k, m);
        for (int i = 0; i < 20; i++) begin
            spi.sdi = 1'($urandom_range(0, 1));
            spi.sck = ~spi.sck;
            tick(H);
        end
        read_result(128);

        // Reset in the middle of a frame
        junk = {rand256(), rand256()};
        send_bits(junk, 60, 1'b0);
        reset    = 1'b1;
        spi.cs_n = 1'b1;
        spi.sdi  = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(3);
        check("rst_ce", 256'(ce), 256'd0);
        check("rst_done", 256'(done), 256'd0);
        check("rst_sdo", 256'(spi.sdo), 256'd0);
        check("rst_dir", 256'(dir), 256'd0);
        check("rst_key", 256'(key), 256'd0);
        check("rst_message", 256'(message), 256'd0);
        r = rand256(); k = r[K-1:0];
        r = rand256(); m = r[127:0];
        r = rand256(); next_result = r[127:0];
        done_delay = 15;
        send_frame(1'b0, k, m);
        read_result(128);

`ifdef AES_SPI_FRAMECHECK_EN
        // Short frame is rejected; the next valid frame clears the error
        junk = {rand256(), rand256()};
        send_bits(junk, 100, 1'b1);
        tick(5);
        check("short_frame_err", 256'(frame_err), 256'd1);
        check("short_key", 256'(key), 256'(mdl_key));
        check("short_message", 256'(message), 256'(mdl_msg));
        check("short_dir", 256'(dir), 256'(mdl_dir));
        r = rand256(); k = r[K-1:0];
        r = rand256(); m = r[127:0];
        r = rand256(); next_result = r[127:0];
        done_delay = 9;
        send_frame(1'b1, k, m);
        check("valid_frame_err", 256'(frame_err), 256'd0);
        read_result(128);
`endif

        tick(10);
        check("ce_missing", 256'(exp_frames.size()), 256'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
